trivium64_sched: RTL and testbench
==================================

// Module: trivium64_sched
// PURPOSE
//  Sequences and shares one trivium64_update core. Handles seed loading and the
//  1152-round (18 x 64-bit) warm-up, then serves random words to NUM_REQ requesters.
//  Requesters are served round-robin, one word per cycle.
//  Sits between the core and the sampler units in RandomSampling.
// PARAMETERS
//  NUM_REQ       4   number of requesters (>=1)
//  WARMUP_STEPS  18  core enable cycles discarded after a seed load (0 = no warm-up)
//  MAX_WORDS     0   words served per seed before reseed is forced (0 = unlimited)
//  CNT_W         32  width of word_cnt
// PORTS
//  clk             in   1        clock, rising edge
//  rst_n           in   1        asynchronous active-low reset
//  seed_valid      in   1        seed offered
//  seed_ready      out  1        seed accepted when seed_valid & seed_ready
//  seed            in   64       seed value
//  req             in   NUM_REQ  per-requester word request (level)
//  gnt             out  NUM_REQ  one-hot grant; word transferred when req[i] & gnt[i]
//  rnd_data        out  64       random word, valid in any cycle with |gnt
//  prng_ready      out  1        state == READY
//  word_cnt        out  CNT_W    words served since last seed load
//  core_load_seed  out  1        to core load_seed
//  core_enable     out  1        to core enable
//  core_seed       out  64       to core seed
//  core_tout       in   64       from core tout
// BEHAVIOUR
//  States: IDLE, WARMUP, READY, EXHAUSTED. Reset -> IDLE.
//   Reset also clears step counter, word_cnt and RR pointer (requester 0 highest).
//  Outputs are combinational decodes of state/inputs.
//   In reset: gnt=0, core_enable=0, core_load_seed=0, prng_ready=0, seed_ready=1, word_cnt=0.
//  core_seed = seed always.
//  core_load_seed = seed_valid & seed_ready. The seed is loaded into the core at that edge.
//  IDLE: seed_ready=1, gnt=0. On seed handshake -> WARMUP (or READY if WARMUP_STEPS=0).
//  WARMUP:
//   - seed_ready=0; seed_valid is ignored; gnt=0.
//   - core_enable=1 every cycle; exactly WARMUP_STEPS enable cycles.
//   - Then -> READY.
//  READY: seed_ready=1.
//   - Seed handshake takes priority: gnt=0 and core_enable=0 that cycle.
//     word_cnt<=0; -> WARMUP.
//   - Else, if |req: grant the first requester at or after the RR pointer.
//     gnt one-hot; rnd_data=core_tout; core_enable=1.
//     word_cnt+1; pointer <= grantee+1 (mod NUM_REQ).
//   - No req: core_enable=0; core state frozen.
//  Each word is used exactly once. Consecutive grants carry consecutive core outputs.
//  rnd_data = core_tout in all states; only meaningful while |gnt.
//  If MAX_WORDS!=0 and a grant brings word_cnt to MAX_WORDS -> EXHAUSTED next cycle.
//  EXHAUSTED: gnt=0, core_enable=0, seed_ready=1. Seed handshake -> WARMUP (word_cnt<=0).
//  word_cnt saturates at all-ones; it never wraps.
//  rst_n low in any state (including mid-WARMUP): immediate return to IDLE.
//   Core content is stale; a new seed is required before any grant.
//  Outside WARMUP, core_enable=1 iff |gnt. core_load_seed and core_enable are never high together.
// TESTING
//  1 Reset:
//    rst_n=0 mid-cycle -> gnt=0, seed_ready=1, prng_ready=0, word_cnt=0 immediately.
//  2 Seed and warm-up:
//    seed=64'h0123_4567_89AB_CDEF, WARMUP_STEPS=18 -> core_enable high exactly 18 cycles.
//    prng_ready on the 19th cycle after the handshake.
//    First granted rnd_data matches the C golden model after 18 steps.
//  3 Round-robin:
//    req=4'b1111 held 8 cycles -> gnt 0001,0010,0100,1000, repeated.
//    word_cnt=8; words equal golden model outputs 0..7.
//  4 Fairness:
//    req=4'b0101 -> gnt alternates 0001/0100.
//    Drop req[0] -> 0100 every cycle.
//    No gnt when req=0, and core_enable=0.
//  5 Reseed in READY with req=4'b1111 -> that cycle gnt=0 and core_load_seed=1.
//    Then 18 WARMUP cycles with seed_ready=0; a seed_valid pulse there is ignored.
//    word_cnt=0 on re-entry to READY.
//  6 MAX_WORDS=4:
//    4 grants -> EXHAUSTED; gnt stays 0 with req=4'b1111.
//    Reseed -> service resumes after warm-up.

Source files
------------

// File: rtl/trivium64_sched.sv
// trivium64_sched - seed/warm-up sequencer and round-robin word server for one shared trivium64 core.
module trivium64_sched #(
  parameter int NUM_REQ      = 4,
  parameter int WARMUP_STEPS = 18,
  parameter int MAX_WORDS    = 0,
  parameter int CNT_W        = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               seed_valid,
  output logic               seed_ready,
  input  logic [63:0]        seed,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [63:0]        rnd_data,
  output logic               prng_ready,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               core_load_seed,
  output logic               core_enable,
  output logic [63:0]        core_seed,
  input  logic [63:0]        core_tout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'((WARMUP_STEPS > 0) ? WARMUP_STEPS - 1 : 0);

  typedef enum logic [1:0] {IDLE, WARMUP, READY, EXHAUSTED} state_e;

  // With no warm-up a freshly loaded seed is immediately servable.
  localparam state_e AFTER_SEED = (WARMUP_STEPS == 0) ? READY : WARMUP;

  state_e           state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             seed_hs;
  logic             found;
  logic [PW-1:0]    grant_idx;

  assign seed_ready     = (state_q != WARMUP);
  assign seed_hs        = seed_valid & seed_ready;
  assign core_load_seed = seed_hs;
  assign core_seed      = seed;
  assign rnd_data       = core_tout;
  assign prng_ready     = (state_q == READY);
  assign word_cnt       = word_cnt_q;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    ptr_d       = ptr_q;
    word_cnt_d  = word_cnt_q;
    gnt         = '0;
    core_enable = 1'b0;
    found       = 1'b0;
    grant_idx   = '0;

    // Search starts at the pointer so the last grantee gets lowest priority.
    for (int k = 0; k < NUM_REQ; k++) begin
      int ci;
      ci = int'(ptr_q) + k;
      if (ci >= NUM_REQ) ci = ci - NUM_REQ;
      if (!found && req[PW'(ci)]) begin
        found     = 1'b1;
        grant_idx = PW'(ci);
      end
    end

    case (state_q)
      IDLE: begin
        if (seed_hs) begin
          state_d    = AFTER_SEED;
          step_d     = '0;
          word_cnt_d = '0;
        end
      end
      WARMUP: begin
        core_enable = 1'b1;
        if (step_q == STEP_LAST) state_d = READY;
        else                     step_d  = step_q + 1'b1;
      end
      READY: begin
        if (seed_hs) begin
          state_d    = AFTER_SEED;
          step_d     = '0;
          word_cnt_d = '0;
        end else if (found) begin
          gnt[grant_idx] = 1'b1;
          core_enable    = 1'b1;
          ptr_d          = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          if (word_cnt_q != '1) word_cnt_d = word_cnt_q + 1'b1;
          if (MAX_WORDS != 0 && 64'(word_cnt_d) == 64'(MAX_WORDS)) state_d = EXHAUSTED;
        end
      end
      EXHAUSTED: begin
        if (seed_hs) begin
          state_d    = AFTER_SEED;
          step_d     = '0;
          word_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      ptr_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      ptr_q      <= ptr_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_trivium64_sched.sv
// tb_trivium64_sched - checks trivium64_sched against a stand-in core and a round-robin reference model.
module tb_trivium64_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        seed_valid = 1'b0;
  logic [63:0] seed = '0;
  logic [3:0]  req = '0;

  logic        seed_ready_a, prng_a, load_a, en_a;
  logic [3:0]  gnt_a;
  logic [63:0] rnd_a, cseed_a, st_a = '0;
  logic [31:0] cnt_a;
  logic        seed_ready_b, prng_b, load_b, en_b;
  logic [3:0]  gnt_b;
  logic [63:0] rnd_b, cseed_b, st_b = '0;
  logic [31:0] cnt_b;

  int          n_chk = 0, n_fail = 0, overlap = 0;
  int          mptr = 0, widx = 0;
  logic [63:0] cur_seed = '0;

  localparam logic [63:0] S0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] S1 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] S2 = 64'h0F1E_2D3C_4B5A_6978;

  always #5 clk = ~clk;

  trivium64_sched u_a (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_ready(seed_ready_a), .seed(seed),
    .req(req), .gnt(gnt_a), .rnd_data(rnd_a), .prng_ready(prng_a), .word_cnt(cnt_a),
    .core_load_seed(load_a), .core_enable(en_a), .core_seed(cseed_a), .core_tout(st_a)
  );

  trivium64_sched #(.MAX_WORDS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_ready(seed_ready_b), .seed(seed),
    .req(req), .gnt(gnt_b), .rnd_data(rnd_b), .prng_ready(prng_b), .word_cnt(cnt_b),
    .core_load_seed(load_b), .core_enable(en_b), .core_seed(cseed_b), .core_tout(st_b)
  );

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  function automatic logic [63:0] gold(input logic [63:0] s, input int n);
    logic [63:0] y;
    y = s;
    for (int i = 0; i < n; i++) y = xs(y);
    return y;
  endfunction

  // Stand-in cores: load on load_seed, advance one step per enable, output current state.
  always @(posedge clk) begin
    if (load_a) st_a <= cseed_a; else if (en_a) st_a <= xs(st_a);
    if (load_b) st_b <= cseed_b; else if (en_b) st_b <= xs(st_b);
  end

  always @(negedge clk) if ((load_a && en_a) || (load_b && en_b)) overlap++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void rr(input logic [3:0] r, input int p, output logic [3:0] g, output int np);
    g  = '0;
    np = p;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (r[i] && g == 0) begin
        g[i] = 1'b1;
        np   = (i + 1) % 4;
      end
    end
  endfunction

  task automatic check_a();
    logic [3:0] eg;
    int         np;
    rr(req, mptr, eg, np);
    chk("rr_gnt", gnt_a, eg);
    chk("rr_en", en_a, |eg);
    if (eg != 0) begin
      chk("rr_data", rnd_a, gold(cur_seed, 18 + widx));
      widx++;
      mptr = np;
    end
  endtask

  task automatic do_seed(input logic [63:0] s, input bit pulse);
    int n, ens;
    bit bad;
    seed = s;
    seed_valid = 1'b1;
    #1;
    chk("hs_load", load_a, 1);
    chk("hs_gnt", gnt_a, 0);
    chk("hs_en", en_a, 0);
    @(negedge clk);
    cur_seed = s;
    widx = 0;
    ens = 0;
    bad = 0;
    for (n = 1; n <= 40; n++) begin
      seed_valid = pulse && (n == 5);
      seed = seed_valid ? ~s : s;
      #1;
      if (prng_a) break;
      ens += int'(en_a);
      bad |= seed_ready_a | load_a | (gnt_a != 0);
      @(negedge clk);
    end
    seed_valid = 1'b0;
    seed = s;
    chk("ready_cycle", 64'(n), 19);
    chk("warm_en_cycles", 64'(ens), 18);
    chk("warm_flags", bad, 0);
    chk("cnt_after_seed", cnt_a, 0);
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    int         cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001, 0};
    tbl[1]  = '{4'b1111, 4'b0010, 1};
    tbl[2]  = '{4'b1111, 4'b0100, 2};
    tbl[3]  = '{4'b1111, 4'b1000, 3};
    tbl[4]  = '{4'b1111, 4'b0001, 4};
    tbl[5]  = '{4'b1111, 4'b0010, 5};
    tbl[6]  = '{4'b1111, 4'b0100, 6};
    tbl[7]  = '{4'b1111, 4'b1000, 7};
    tbl[8]  = '{4'b0101, 4'b0001, 8};
    tbl[9]  = '{4'b0101, 4'b0100, 9};
    tbl[10] = '{4'b0101, 4'b0001, 10};
    tbl[11] = '{4'b0101, 4'b0100, 11};
    tbl[12] = '{4'b0100, 4'b0100, 12};
    tbl[13] = '{4'b0100, 4'b0100, 13};
    tbl[14] = '{4'b0000, 4'b0000, 14};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt", gnt_a, 0);
    chk("rst_seed_ready", seed_ready_a, 1);
    chk("rst_prng_ready", prng_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_en_load", {en_a, load_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_seed(S0, 1'b0);

    foreach (tbl[i]) begin
      logic [3:0] eg;
      int         np;
      req = tbl[i].req;
      #1;
      chk("tbl_gnt", gnt_a, tbl[i].gnt);
      chk("tbl_cnt", cnt_a, 64'(tbl[i].cnt));
      chk("tbl_en", en_a, |tbl[i].gnt);
      if (tbl[i].gnt != 0) begin
        chk("tbl_data", rnd_a, gold(cur_seed, 18 + widx));
        widx++;
      end
      rr(tbl[i].req, mptr, eg, np);
      mptr = np;
      @(negedge clk);
    end

    req = 4'b1111;
    do_seed(S1, 1'b1);

    for (int k = 0; k < 6; k++) begin
      req = 4'b1111;
      #1;
      check_a();
      chk("ex_gnt", gnt_b, (k < 4) ? (4'b0001 << k) : 4'b0000);
      chk("ex_en", en_b, k < 4);
      if (k < 4) chk("ex_data", rnd_b, gold(S1, 18 + k));
      if (k == 5) begin
        chk("ex_prng_ready", prng_b, 0);
        chk("ex_cnt", cnt_b, 4);
        chk("ex_seed_ready", seed_ready_b, 1);
      end
      @(negedge clk);
    end

    do_seed(S2, 1'b0);
    req = 4'b0001;
    #1;
    check_a();
    chk("resume_cnt_b", cnt_b, 0);
    chk("resume_gnt_b", gnt_b, 4'b0001);
    chk("resume_data_b", rnd_b, gold(S2, 18));
    @(negedge clk);

    for (int k = 0; k < 120; k++) begin
      req = 4'($urandom_range(0, 15));
      #1;
      check_a();
      @(negedge clk);
    end
    chk("rand_cnt", cnt_a, 64'(widx));

    req = 4'b1111;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt_a, 0);
    chk("midrst_seed_ready", seed_ready_a, 1);
    chk("midrst_prng_ready", prng_a, 0);
    chk("midrst_cnt", cnt_a, 0);
    chk("midrst_en", en_a, 0);
    @(negedge clk);
    #1;
    chk("midrst_hold_gnt", gnt_a, 0);
    chk("load_en_exclusive", 64'(overlap), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
